// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the matching receiver.
//   uart_state_e   : frame FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4)
//   OVERSAMPLE_DEF : default br_tick pulses per serial bit
//   DATA_BITS_DEF  : default payload bits per frame
//   cnt_width()    : counter width for a modulo-n counter, never narrower than 1 bit
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StStop   = 3'd3,
        StParity = 3'd4
    } uart_state_e;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one DATA_BITS-wide word per request as
// start bit (0), data bits LSB first, optional even parity bit, stop bit (1).
// Each bit lasts OVERSAMPLE pulses of br_tick from the shared external baud_gen.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. Without it the parity state and
// parity logic are not built and DATA goes straight to STOP.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   br_tick  in   one-clk oversample strobe
//   tx_start in   request to send tx_data (honoured only when idle)
//   tx_data  in   word to send, captured on acceptance
//   tx       out  serial line, registered, idle high
//   tx_busy  out  high from acceptance until the frame ends
//   tx_done  out  one-clk pulse on the final stop-bit tick
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned TickW = cnt_width(OVERSAMPLE);
    localparam int unsigned BitW  = cnt_width(DATA_BITS);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Last oversample tick of the current bit.
    assign bit_end   = br_tick && (tick_q == TickLast);
    assign shift_nxt = shift_q >> 1;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != StIdle && br_tick) begin
            tick_d = bit_end ? '0 : tick_q + TickW'(1);
        end

        case (state_q)
            StIdle: begin
                // done_q still high means the frame ended on the previous edge;
                // a request in that cycle is deliberately not taken.
                if (tx_start && !done_q) begin
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                    state_d = StStart;
                    tick_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == BitLast) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = par_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + BitW'(1);
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (default parameters).
// A frame-level reference model (list of line levels, one per bit, indexed by
// br_ticks elapsed since acceptance) is compared against tx/tx_busy/tx_done
// every cycle; a table of words with hand-computed parity is also checked
// bit by bit at mid-bit, followed by hand-written corner sequences and a
// randomized run.
module tb_uart_transmitter;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DB + 3;
`else
    localparam int NBITS = DB + 2;
`endif
    localparam int TICK_PERIOD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          br_tick;
    logic          tx_start;
    logic [DB-1:0] tx_data;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;

    uart_transmitter dut (
        .clk      (clk),
        .reset    (reset),
        .br_tick  (br_tick),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t tbl[8];

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_done = 0;
    int   cyc    = 0;
    int   tcnt   = 0;
    bit   rnd_tick = 1'b0;

    // Reference model.
    bit   m_active = 1'b0;
    bit   m_done   = 1'b0;
    int   m_ticks  = 0;
    logic m_bits[NBITS];
    logic cap[NBITS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_ticks  = 0;
    endtask

    // One clock edge: update the model from the inputs seen at the edge,
    // then compare the DUT 1 time unit later.
    task automatic step();
        bit   dn;
        logic exp_tx;
        @(posedge clk);
        cyc++;
        dn = 1'b0;
        if (reset) begin
            model_reset();
        end else if (!m_active) begin
            if (tx_start && !m_done) begin
                m_active = 1'b1;
                m_ticks  = 0;
                m_bits[0] = 1'b0;
                for (int i = 0; i < DB; i++) m_bits[1+i] = tx_data[i];
`ifdef UART_TX_PARITY_EN
                m_bits[DB+1] = ^tx_data;
`endif
                m_bits[NBITS-1] = 1'b1;
                for (int i = 0; i < NBITS; i++) cap[i] = 1'bx;
            end
        end else if (br_tick) begin
            m_ticks++;
            if (m_ticks == NBITS * OS) begin
                m_active = 1'b0;
                dn = 1'b1;
            end
        end
        if (!reset) m_done = dn;
        #1;
        exp_tx = m_active ? m_bits[m_ticks / OS] : 1'b1;
        check("tx", tx, exp_tx);
        check("tx_busy", tx_busy, m_active);
        check("tx_done", tx_done, m_done);
        if (tx_done) n_done++;
        if (m_active && br_tick && (m_ticks % OS) == OS / 2) cap[m_ticks / OS] = tx;
    endtask

    task automatic tstep();
        if (rnd_tick) begin
            br_tick = ($urandom_range(0, 2) == 0);
        end else begin
            br_tick = (tcnt == TICK_PERIOD - 1);
            tcnt = (tcnt + 1) % TICK_PERIOD;
        end
        step();
    endtask

    // Periodic ticks; the acceptance edge coincides with a tick edge.
    task automatic send(input logic [7:0] d);
        while (tcnt != TICK_PERIOD - 1) tstep();
        tx_start = 1'b1;
        tx_data  = d;
        tstep();
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int c = 0;
        while ((m_active || m_done) && c < maxc) begin
            tx_data = DB'($urandom);
            tstep();
            c++;
        end
        check({nm, "_timeout"}, {31'd0, m_active}, 32'd0);
    endtask

    task automatic run_to_ticks(input int target);
        int c = 0;
        while (m_active && m_ticks < target && c < 5000) begin
            tstep();
            c++;
        end
    endtask

    task automatic check_frame(input string nm, input logic [7:0] d, input logic p);
        check({nm, "_start"}, cap[0], 1'b0);
        for (int i = 0; i < DB; i++) check($sformatf("%s_d%0d", nm, i), cap[1+i], d[i]);
`ifdef UART_TX_PARITY_EN
        check({nm, "_par"}, cap[DB+1], p);
`else
        if (p === 1'bx) $display("note: parity table entry undefined for %s", nm);
`endif
        check({nm, "_stop"}, cap[NBITS-1], 1'b1);
    endtask

    initial begin
        int blen;
        int d0;
        int last_done;
        logic prev_tx;
        logic frz_tx;

        tbl[0].data = 8'h55; tbl[0].par = 1'b0;
        tbl[1].data = 8'hA3; tbl[1].par = 1'b0;
        tbl[2].data = 8'h01; tbl[2].par = 1'b1;
        tbl[3].data = 8'h00; tbl[3].par = 1'b0;
        tbl[4].data = 8'hFF; tbl[4].par = 1'b0;
        tbl[5].data = 8'h3C; tbl[5].par = 1'b0;
        tbl[6].data = 8'h80; tbl[6].par = 1'b1;
        tbl[7].data = 8'h7F; tbl[7].par = 1'b1;

        reset = 1'b1; br_tick = 1'b0; tx_start = 1'b0; tx_data = '0;
        #3;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        tstep(); tstep();
        reset = 1'b0;
        tstep(); tstep();

        // Table-driven frames, br_tick every 4 clk, tx_data scrambled after acceptance.
        foreach (tbl[k]) begin
            d0 = n_done;
            send(tbl[k].data);
            blen = 1;
            while (m_active && blen < 2000) begin
                tx_data = DB'($urandom);
                tstep();
                if (tx_busy) blen++;
            end
            wait_idle($sformatf("tbl%0d", k), 10);
            check($sformatf("tbl%0d_busy_len", k), blen, NBITS * OS * TICK_PERIOD);
            check($sformatf("tbl%0d_done_cnt", k), n_done - d0, 1);
            check_frame($sformatf("tbl%0d", k), tbl[k].data, tbl[k].par);
        end

        // Request with 0xFF during DATA of a 0x00 frame is ignored.
        d0 = n_done;
        send(8'h00);
        run_to_ticks(3 * OS + 5);
        tx_start = 1'b1; tx_data = 8'hFF; tstep(); tx_start = 1'b0;
        wait_idle("ign", 2000);
        for (int i = 0; i < 50; i++) tstep();
        check("ign_done_cnt", n_done - d0, 1);
        check("ign_no_second", tx_busy, 1'b0);
        check_frame("ign", 8'h00, 1'b0);

        // Reset during data bit 3 aborts the frame without tx_done.
        d0 = n_done;
        send(8'h00);
        run_to_ticks(4 * OS + 3);
        reset = 1'b1;
        #1;
        model_reset();
        check("abort_tx", tx, 1'b1);
        check("abort_busy", tx_busy, 1'b0);
        check("abort_done", tx_done, 1'b0);
        tstep(); tstep();
        reset = 1'b0;
        tstep(); tstep();
        check("abort_no_done", n_done - d0, 0);
        send(8'h3C);
        wait_idle("post_rst", 2000);
        check("post_rst_done", n_done - d0, 1);
        check_frame("post_rst", 8'h3C, 1'b0);

        // tx_start held high: back-to-back frames, start bit 2 edges after tx_done rises.
        d0 = n_done;
        last_done = -1;
        prev_tx = tx;
        tx_start = 1'b1; tx_data = 8'h5A;
        blen = 0;
        while (n_done - d0 < 3 && blen < 4 * NBITS * OS * TICK_PERIOD) begin
            tstep();
            blen++;
            if (tx_done) last_done = cyc;
            if (prev_tx && !tx && last_done >= 0) begin
                check("b2b_gap", cyc - last_done, 2);
                last_done = -1;
            end
            prev_tx = tx;
        end
        check("b2b_frames", n_done - d0, 3);
        tx_start = 1'b0;
        wait_idle("b2b", 2000);

        // br_tick held low 100 clk mid-bit: line frozen, frame resumes intact.
        d0 = n_done;
        send(8'h55);
        run_to_ticks(2 * OS + 7);
        frz_tx = tx;
        br_tick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check("freeze_tx", tx, frz_tx);
        end
        wait_idle("freeze", 2000);
        check("freeze_done", n_done - d0, 1);
        check_frame("freeze", 8'h55, 1'b0);

        // Randomized traffic against the model.
        rnd_tick = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            tx_start = ($urandom_range(0, 15) == 0);
            tx_data  = DB'($urandom);
            if ($urandom_range(0, 3999) == 0) begin
                reset = 1'b1;
                tstep();
                reset = 1'b0;
            end else begin
                tstep();
            end
        end
        tx_start = 1'b0;
        wait_idle("rnd", 5000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, number of br_tick pulses per serial bit.
REQ-002 Parameter: DATA_BITS, default 8, number of payload bits per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port br_tick, input, 1 bit: one-clk-wide oversample strobe from the shared baud generator.
REQ-006 The block SHALL have port tx_start, input, 1 bit: request to send tx_data.
REQ-007 The block SHALL have port tx_data, input, DATA_BITS bits: byte to send.
REQ-008 The block SHALL have port tx, output, 1 bit: serial line, registered, idle high.
REQ-009 The block SHALL have port tx_busy, output, 1 bit: high from acceptance until the frame ends.
REQ-010 The block SHALL have port tx_done, output, 1 bit: one-clk pulse at the end of the stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, and SHALL return to IDLE after STOP.
REQ-012 Acceptance: when tx_start=1 in IDLE at edge N, the block SHALL capture tx_data into its shift register; after edge N, state=START, tx=0, tx_busy=1, tick count=0.
REQ-013 tx_start SHALL be ignored in every state other than IDLE; the captured byte SHALL be immune to tx_data changes after acceptance.
REQ-014 The tick counter SHALL advance only on cycles with br_tick=1; with br_tick=0, state, tick count and tx SHALL hold.
REQ-015 Each bit SHALL last exactly OVERSAMPLE br_ticks: on the br_tick where count==OVERSAMPLE-1, the count SHALL wrap to 0 and the FSM SHALL move to the next bit/state.
REQ-016 DATA SHALL send DATA_BITS bits LSB first, SHALL shift right once per bit boundary, and SHALL use a bit counter of clog2(DATA_BITS) bits that leaves DATA after bit DATA_BITS-1.
REQ-017 STOP SHALL drive tx=1 for OVERSAMPLE br_ticks; on its final br_tick the FSM SHALL go to IDLE, drive tx_done=1 for exactly that one clk, and deassert tx_busy on the same edge.
REQ-018 tx_start asserted in the same cycle tx_done is high SHALL NOT be accepted; a request one cycle later SHALL be accepted.
REQ-019 tx SHALL come straight from a flop, with no combinational path from inputs to tx.
REQ-020 Frame length SHALL be (DATA_BITS+2)*OVERSAMPLE br_ticks, or (DATA_BITS+3)*OVERSAMPLE with parity.

Reset
REQ-021 Reset SHALL force, asynchronously: state=IDLE, tx=1, tx_busy=0, tx_done=0, tick count=0, bit count=0, shift register=0.
REQ-022 Reset mid-frame SHALL abort the frame with no tx_done; after release the block SHALL be IDLE and accept the next tx_start.

Configuration
REQ-023 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and send even parity (XOR of the captured byte) for OVERSAMPLE br_ticks before STOP.
REQ-024 With UART_TX_PARITY_EN undefined, the PARITY state and the parity logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-025 Shared package uart_pkg SHALL hold the state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4), the OVERSAMPLE default and the DATA_BITS default; the matching receiver SHALL use the same package.
REQ-026 No sub-module SHALL be instantiated; br_tick SHALL come from the existing external baud_gen.

Verification
REQ-027 br_tick every 4 clk, tx_start with 0x55 -> tx holds 0,1,0,1,0,1,0,1,0,1 for 64 clk each; one tx_done pulse; tx_busy high 640 clk.
REQ-028 UART_TX_PARITY_EN defined, send 0xA3 -> data bits 1,1,0,0,0,1,0,1, then parity bit 0, then stop 1; send 0x01 -> parity bit 1.
REQ-029 tx_start pulsed with 0xFF during the DATA state of a 0x00 frame -> the frame stays all-zero data, with no second frame and exactly one tx_done.
REQ-030 Reset asserted at data bit 3 -> tx=1 immediately, tx_busy=0, no tx_done; a new 0x3C sent afterwards is correct.
REQ-031 tx_start held high continuously -> back-to-back frames; the next start bit falls exactly 1 clk after each tx_done, and no request is accepted in the tx_done cycle.
REQ-032 br_tick held low for 100 clk mid-bit -> tx and state frozen; the frame resumes with the remaining tick count unchanged.
